// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master (CPU/DMA) arbiter for single-port data memory
module dmem_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 32,
   parameter int STARVE_LIMIT = 3,
   parameter int DMA_BURST    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_rvalid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam int BW = (DMA_BURST > 0) ? $clog2(DMA_BURST + 1) : 1;
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [BW-1:0] BURST_MAX  = BW'(DMA_BURST);

   typedef enum logic {
      ST_CPU_PRI   = 1'b0,
      ST_DMA_BURST = 1'b1
   } state_t;

   state_t            st_q, st_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic [BW-1:0]     burst_q, burst_d;
   logic [DATA_W-1:0] dma_rdata_q;
   logic              dma_rvalid_q;

   logic              force_dma;
   logic              dma_gnt_w;
   logic              cpu_gnt;
   logic [BW-1:0]     burst_inc;

   // Grant decision: CPU wins by default unless the DMA has starved long
   // enough or a forced burst is in progress; everything is gated in reset.
   always_comb begin
      force_dma = (st_q == ST_CPU_PRI) && (starve_q == STARVE_MAX);
      dma_gnt_w = 1'b0;
      if (reset) begin
         if (st_q == ST_DMA_BURST) begin
            dma_gnt_w = dma_req;
         end else begin
            dma_gnt_w = dma_req & (~cpu_req | force_dma);
         end
      end
      cpu_gnt = reset & cpu_req & ~dma_gnt_w;
   end

   // Memory port mux and master-facing combinational outputs.
   always_comb begin
      mem_addr  = dma_gnt_w ? dma_addr  : cpu_addr;
      mem_wdata = dma_gnt_w ? dma_wdata : cpu_wdata;
      mem_we    = (cpu_gnt & cpu_we) | (dma_gnt_w & dma_we);
      cpu_stall = reset & cpu_req & ~cpu_gnt;
      dma_gnt   = dma_gnt_w;
      cpu_rdata = mem_rdata;
   end

   // Next-state for the arbitration FSM and its starvation/burst counters.
   always_comb begin
      st_d      = st_q;
      starve_d  = starve_q;
      burst_d   = burst_q;
      burst_inc = burst_q + 1'b1;

      if (dma_req && !dma_gnt_w) begin
         starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
      end else begin
         starve_d = '0;
      end

      case (st_q)
         ST_CPU_PRI: begin
            // Only a forced grant against a live CPU request opens a burst.
            if (force_dma && dma_gnt_w && cpu_req && (DMA_BURST > 1)) begin
               st_d    = ST_DMA_BURST;
               burst_d = BW'(1);
            end
         end
         ST_DMA_BURST: begin
            if (!dma_req) begin
               st_d    = ST_CPU_PRI;
               burst_d = '0;
            end else if (burst_inc == BURST_MAX) begin
               st_d    = ST_CPU_PRI;
               burst_d = '0;
            end else begin
               burst_d = burst_inc;
            end
         end
         default: begin
            st_d    = ST_CPU_PRI;
            burst_d = '0;
         end
      endcase
   end

   // State registers plus registered DMA read return path.
   always_ff @(posedge clk) begin
      if (!reset) begin
         st_q         <= ST_CPU_PRI;
         starve_q     <= '0;
         burst_q      <= '0;
         dma_rvalid_q <= 1'b0;
         dma_rdata_q  <= '0;
      end else begin
         st_q     <= st_d;
         starve_q <= starve_d;
         burst_q  <= burst_d;
         if (dma_gnt_w && !dma_we) begin
            dma_rdata_q  <= mem_rdata;
            dma_rvalid_q <= 1'b1;
         end else begin
            dma_rvalid_q <= 1'b0;
         end
      end
   end

   assign dma_rdata  = dma_rdata_q;
   assign dma_rvalid = dma_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - table-driven bench for dmem_arbiter
module tb_dmem_arbiter;

   logic        clk;
   logic        reset;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        cpu_stall, dma_gnt, dma_rvalid, mem_we;

   logic [31:0] mem [0:255];

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        rst;
      logic        creq, cwe;
      logic [31:0] caddr, cwd;
      logic        dreq, dwe;
      logic [31:0] daddr, dwd;
      logic        e_stall, e_dgnt, e_we;
      logic [31:0] e_addr;
      logic        c_crd;
      logic [31:0] e_crd;
      logic        e_rv;
      logic        c_drd;
      logic [31:0] e_drd;
   } vec_t;

   vec_t tbl[$];

   dmem_arbiter #(
      .DATA_W(32), .ADDR_W(32), .STARVE_LIMIT(3), .DMA_BURST(2)
   ) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
      .dma_rvalid(dma_rvalid),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural DMEM: async read, write on rising edge.
   assign mem_rdata = mem[mem_addr[7:0]];
   always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

   function automatic vec_t mk(
      logic rst, logic creq, logic cwe, logic [31:0] caddr, logic [31:0] cwd,
      logic dreq, logic dwe, logic [31:0] daddr, logic [31:0] dwd,
      logic es, logic eg, logic ew, logic [31:0] ea,
      logic ccrd, logic [31:0] ecrd, logic erv, logic cdrd, logic [31:0] edrd);
      vec_t v;
      v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
      v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
      v.e_stall = es; v.e_dgnt = eg; v.e_we = ew; v.e_addr = ea;
      v.c_crd = ccrd; v.e_crd = ecrd; v.e_rv = erv; v.c_drd = cdrd; v.e_drd = edrd;
      return v;
   endfunction

   // Both masters reading continuously: CPU at 0x10, DMA at 0x20.
   function automatic vec_t cont(logic stall, logic rv);
      return mk(1, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0,
                stall, stall, 0, stall ? 32'h20 : 32'h10,
                !stall, 32'hDEADBEEF, rv, rv, 32'h12345678);
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      reset = v.rst;
      cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
      dma_req = v.dreq; dma_we = v.dwe; dma_addr = v.daddr; dma_wdata = v.dwd;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      reset = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
      @(posedge clk);

      // reset held with both requests (writes) pending
      tbl.push_back(mk(0, 1,1,32'h10,32'hAAAA, 1,1,32'h20,32'hBBBB, 0,0,0,32'h10, 0,0, 0,0,0));
      tbl.push_back(mk(0, 1,1,32'h10,32'hAAAA, 1,1,32'h20,32'hBBBB, 0,0,0,32'h10, 0,0, 0,0,0));
      // release: CPU wins first cycle
      tbl.push_back(mk(1, 1,0,32'h40,0, 1,0,32'h44,0, 0,0,0,32'h40, 0,0, 0,0,0));
      // CPU only write then read
      tbl.push_back(mk(1, 1,1,32'h10,32'hDEADBEEF, 0,0,0,0, 0,0,1,32'h10, 0,0, 0,0,0));
      tbl.push_back(mk(1, 1,0,32'h10,0, 0,0,0,0, 0,0,0,32'h10, 1,32'hDEADBEEF, 0,0,0));
      // DMA only write then read, rvalid one cycle later, data then holds
      tbl.push_back(mk(1, 0,0,0,0, 1,1,32'h20,32'h12345678, 0,1,1,32'h20, 0,0, 0,0,0));
      tbl.push_back(mk(1, 0,0,0,0, 1,0,32'h20,0, 0,1,0,32'h20, 0,0, 0,0,0));
      tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,32'h0, 0,0, 1,1,32'h12345678));
      tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,32'h0, 0,0, 0,1,32'h12345678));
      // contention 3:2 pattern, twice, then into a third burst
      tbl.push_back(cont(0,0)); tbl.push_back(cont(0,0)); tbl.push_back(cont(0,0));
      tbl.push_back(cont(1,0)); tbl.push_back(cont(1,1));
      tbl.push_back(cont(0,1)); tbl.push_back(cont(0,0)); tbl.push_back(cont(0,0));
      tbl.push_back(cont(1,0)); tbl.push_back(cont(1,1));
      tbl.push_back(cont(0,1)); tbl.push_back(cont(0,0)); tbl.push_back(cont(0,0));
      tbl.push_back(cont(1,0));
      // DMA drops inside burst after one grant: CPU served same cycle
      tbl.push_back(mk(1, 1,0,32'h10,0, 0,0,32'h20,0, 0,0,0,32'h10, 1,32'hDEADBEEF, 1,1,32'h12345678));
      // back in CPU priority with fresh starvation count
      tbl.push_back(cont(0,0));

      foreach (tbl[k]) begin
         if (k > 0) @(posedge clk);
         #1 drive(tbl[k]);
         @(negedge clk);
         n_vec++;
         chk($sformatf("v%0d cpu_stall", k), 32'(cpu_stall), 32'(tbl[k].e_stall));
         chk($sformatf("v%0d dma_gnt", k), 32'(dma_gnt), 32'(tbl[k].e_dgnt));
         chk($sformatf("v%0d mem_we", k), 32'(mem_we), 32'(tbl[k].e_we));
         chk($sformatf("v%0d mem_addr", k), mem_addr, tbl[k].e_addr);
         chk($sformatf("v%0d dma_rvalid", k), 32'(dma_rvalid), 32'(tbl[k].e_rv));
         if (tbl[k].c_crd) chk($sformatf("v%0d cpu_rdata", k), cpu_rdata, tbl[k].e_crd);
         if (tbl[k].c_drd) chk($sformatf("v%0d dma_rdata", k), dma_rdata, tbl[k].e_drd);
      end

      // Reset mid-burst: run contention until the forced DMA read is granted.
      begin
         bit found;
         found = 0;
         for (int i = 0; i < 8 && !found; i++) begin
            @(posedge clk);
            #1 drive(mk(1, 1,0,32'h10,0, 1,0,32'h20,0, 0,0,0,0, 0,0,0,0,0));
            @(negedge clk);
            if (dma_gnt === 1'b1) found = 1;
         end
         n_vec++;
         if (!found) begin
            n_err++;
            $display("FAIL burst_entry: got no dma_gnt within 8 cycles expected a forced grant");
         end
      end

      @(posedge clk);
      #1 drive(mk(0, 1,1,32'h10,32'h5555, 1,1,32'h20,32'h6666, 0,0,0,0, 0,0,0,0,0));
      @(negedge clk);
      n_vec++;
      chk("rst_burst dma_gnt", 32'(dma_gnt), 32'd0);
      chk("rst_burst mem_we", 32'(mem_we), 32'd0);
      chk("rst_burst cpu_stall", 32'(cpu_stall), 32'd0);
      chk("rst_burst prior_rvalid", 32'(dma_rvalid), 32'd1);

      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1 drive(mk(1, 1,0,32'h10,0, 1,0,32'h20,0, 0,0,0,0, 0,0,0,0,0));
         @(negedge clk);
         n_vec++;
         chk($sformatf("post_rst c%0d cpu_stall", i), 32'(cpu_stall), 32'(i == 3 || i == 4));
         chk($sformatf("post_rst c%0d dma_gnt", i), 32'(dma_gnt), 32'(i == 3 || i == 4));
         chk($sformatf("post_rst c%0d dma_rvalid", i), 32'(dma_rvalid), 32'(i == 4 || i == 5));
      end
      chk("post_rst mem_intact", mem[8'h10], 32'hDEADBEEF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter for the single-port data memory: shares DMEM between the CPU data port and a DMA/loader port. Sits between `CPU`/DMA engine and `DMEM` inside the SoC. Issues at most one memory access per cycle. CPU has default priority; a starvation counter forces bounded DMA bursts. Stalls the CPU while it is locked out.

## Interface
Parameters:
- `DATA_W`, 32, data width of all data ports
- `ADDR_W`, 32, address width of all address ports
- `STARVE_LIMIT`, 3, consecutive cycles a requesting DMA may be denied before forced service (≥1)
- `DMA_BURST`, 2, max consecutive forced DMA grants while CPU is requesting (≥1)

Ports (name, direction, width, meaning):
- `clk`, in, 1, sole clock; all state updates on rising edge
- `reset`, in, 1, synchronous, active-low (0 = reset)
- `cpu_req`, in, 1, CPU requests an access this cycle
- `cpu_we`, in, 1, CPU write enable
- `cpu_addr`, in, ADDR_W, CPU address
- `cpu_wdata`, in, DATA_W, CPU write data
- `cpu_rdata`, out, DATA_W, combinational pass-through of `mem_rdata`
- `cpu_stall`, out, 1, `cpu_req & ~cpu_gnt`; CPU must hold request
- `dma_req`, in, 1, DMA requests an access this cycle
- `dma_we`, in, 1, DMA write enable
- `dma_addr`, in, ADDR_W, DMA address
- `dma_wdata`, in, DATA_W, DMA write data
- `dma_gnt`, out, 1, DMA access performed this cycle
- `dma_rdata`, out, DATA_W, registered DMA read data
- `dma_rvalid`, out, 1, one-cycle pulse: `dma_rdata` valid
- `mem_we`, out, 1, to DMEM `we`
- `mem_addr`, out, ADDR_W, to DMEM `addr`
- `mem_wdata`, out, DATA_W, to DMEM `wdata`
- `mem_rdata`, in, DATA_W, from DMEM `rdata` (asynchronous read)

## Operation
- State: `st` ∈ {CPU_PRI, DMA_BURST}; `starve_cnt` (0..STARVE_LIMIT, saturating); `burst_cnt` (0..DMA_BURST).
- Reset (reset==0 at edge): st=CPU_PRI, starve_cnt=0, burst_cnt=0, dma_rvalid=0, dma_rdata=0. While reset==0, grants, `mem_we`, `cpu_stall` forced 0.
- CPU_PRI grants: `force = (starve_cnt==STARVE_LIMIT)`; `dma_gnt = dma_req & (~cpu_req | force)`; `cpu_gnt = cpu_req & ~dma_gnt`.
- DMA_BURST grants: `dma_gnt = dma_req`; `cpu_gnt = cpu_req & ~dma_req`.
- Mux: DMA granted → mem_* from dma_*; else mem_addr/mem_wdata from cpu_*. `mem_we = (cpu_gnt&cpu_we) | (dma_gnt&dma_we)`; never 1 without a grant.
- starve_cnt: +1 (saturating) when `dma_req & ~dma_gnt`; cleared when dma_gnt or ~dma_req.
- Transitions:
  - CPU_PRI → DMA_BURST when forced grant taken (`force & dma_gnt & cpu_req`) and DMA_BURST>1; burst_cnt←1. If DMA_BURST==1 stay CPU_PRI.
  - DMA_BURST: on dma_gnt, burst_cnt+1; when new burst_cnt==DMA_BURST → CPU_PRI, burst_cnt←0.
  - DMA_BURST with ~dma_req → CPU_PRI, burst_cnt←0 (CPU served same cycle if requesting).
  - Non-forced DMA grants (CPU idle) never enter DMA_BURST.
- DMA read: on edge with `dma_gnt & ~dma_we`: dma_rdata←mem_rdata, dma_rvalid←1; otherwise dma_rvalid←0, dma_rdata holds.
- CPU read: `cpu_rdata` valid in the grant cycle (no added latency vs. direct DMEM).

## Timing
- Grant/stall/mem_* are combinational from registered state + current requests; zero-cycle arbitration.
- Writes commit at the rising edge ending the grant cycle.
- DMA read latency: 1 cycle (grant in cycle N, dma_rvalid in N+1).
- Worst-case CPU stall per starvation episode: DMA_BURST cycles; worst-case DMA wait: STARVE_LIMIT cycles.
- Both masters hold req/addr/data stable until granted; a dropped request is simply not served.
- Reset mid-burst: next cycle st=CPU_PRI, counters 0, pending dma_rvalid cleared.

## Test plan
- Reset: hold reset=0 with both reqs high 2 cycles → mem_we=0, dma_gnt=0, cpu_stall=0; release → CPU granted first cycle.
- CPU only: write 0xDEADBEEF to 0x10, read 0x10 → cpu_stall=0 throughout, cpu_rdata=0xDEADBEEF in read cycle.
- DMA only: write 0x12345678 to 0x20 then read → dma_gnt each cycle, dma_rvalid pulses one cycle after read grant with dma_rdata=0x12345678.
- Contention, defaults: both req continuous → CPU granted 3 cycles (starve_cnt 1,2,3), DMA granted 2 cycles (cpu_stall=1), pattern repeats 3:2.
- DMA drops req during DMA_BURST after 1 grant → same cycle cpu_gnt=1, cpu_stall=0; st back to CPU_PRI.
- Reset asserted in DMA_BURST with a read granted → dma_rvalid=0 next cycle, following contention starts again with 3 CPU grants.
